// File: rtl/calc_cmd_pkg.sv
// Shared encodings for the calculator command-port arbiter: command codes,
// sequencer states and requester indices.
package calc_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_PUSH_LO = 2'b00,
        CMD_PUSH_HI = 2'b01,
        CMD_EXEC    = 2'b10,
        CMD_RSVD    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    localparam logic REQ_BTN  = 1'b0;
    localparam logic REQ_UART = 1'b1;

    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == REQ_UART) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the requester
// that did not win last time. Purely combinational; history lives in the parent.
module rr_arbiter2
    import calc_cmd_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       any_o,
    output logic       grant_o
);

    // Grant selection from the request pair and the previous winner
    always_comb begin
        any_o = |req_i;
        case (req_i)
            2'b11:   grant_o = ~last_grant_i;
            2'b10:   grant_o = REQ_UART;
            default: grant_o = REQ_BTN;
        endcase
    end

endmodule

// File: rtl/calc_cmd_arbiter.sv
// Shares the calculator core between the button panel and the UART decoder:
// grants a command, issues it as a one-cycle core strobe and routes the result back.
module calc_cmd_arbiter
    import calc_cmd_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RESULT_W = 16,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic [1:0]            ReqValid,
    input  logic [3:0]            ReqCmd,
    input  logic [2*DATA_W-1:0]   ReqData,
    output logic [1:0]            ReqReady,
    output logic                  CorePushLow,
    output logic                  CorePushHi,
    output logic                  CoreExecute,
    output logic [DATA_W-1:0]     CoreData,
    input  logic                  CoreBusy,
    input  logic                  CoreDone,
    input  logic [RESULT_W-1:0]   CoreResult,
    output logic [1:0]            RspValid,
    output logic [RESULT_W-1:0]   RspData,
    output logic                  RspError,
    output logic                  Owner
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    cmd_e                cmd_q, cmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [1:0]          req_ready_q, req_ready_d;
    logic                push_lo_q, push_lo_d, push_hi_q, push_hi_d, exec_q, exec_d;
    logic [DATA_W-1:0]   core_data_q, core_data_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [RESULT_W-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_error_q, rsp_error_d;

    logic                arb_any_s, arb_grant_s, grant_ok_s, timeout_s, done_seen_s;
    logic [1:0]          gnt_cmd_s;
    logic [DATA_W-1:0]   gnt_data_s;

    rr_arbiter2 u_arb (
        .req_i        (ReqValid),
        .last_grant_i (last_grant_q),
        .any_o        (arb_any_s),
        .grant_o      (arb_grant_s)
    );

    // The cycle after a strobe is a guard cycle: the granted requester gets time to
    // retire ReqValid, and the core never sees back-to-back strobes.
    assign grant_ok_s  = arb_any_s && !(push_lo_q || push_hi_q || exec_q);
    assign gnt_cmd_s   = arb_grant_s ? ReqCmd[3:2] : ReqCmd[1:0];
    assign gnt_data_s  = arb_grant_s ? ReqData[2*DATA_W-1:DATA_W] : ReqData[DATA_W-1:0];
    assign timeout_s   = (cnt_q == CNT_W'(TIMEOUT));
    // Done is not looked at in the execute strobe cycle itself (counter still zero).
    assign done_seen_s = CoreDone && (cnt_q != {CNT_W{1'b0}});

    // State and datapath registers
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q      <= ST_IDLE;
            cmd_q        <= CMD_PUSH_LO;
            data_q       <= {DATA_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            last_grant_q <= REQ_UART;
            owner_q      <= REQ_BTN;
            req_ready_q  <= 2'b00;
            push_lo_q    <= 1'b0;
            push_hi_q    <= 1'b0;
            exec_q       <= 1'b0;
            core_data_q  <= {DATA_W{1'b0}};
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= {RESULT_W{1'b0}};
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            req_ready_q  <= req_ready_d;
            push_lo_q    <= push_lo_d;
            push_hi_q    <= push_hi_d;
            exec_q       <= exec_d;
            core_data_q  <= core_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok_s) state_d = ST_ISSUE;
                else            state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (CoreBusy) begin
                    state_d = ST_ISSUE;
                end else begin
                    case (cmd_q)
                        CMD_PUSH_LO, CMD_PUSH_HI: state_d = ST_IDLE;
                        CMD_EXEC:                 state_d = ST_WAIT_DONE;
                        default:                  state_d = ST_RESP;
                    endcase
                end
            end
            ST_WAIT_DONE: begin
                if (done_seen_s || timeout_s) state_d = ST_RESP;
                else                          state_d = ST_WAIT_DONE;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; pulses default low every cycle
    always_comb begin
        req_ready_d  = 2'b00;
        push_lo_d    = 1'b0;
        push_hi_d    = 1'b0;
        exec_d       = 1'b0;
        rsp_valid_d  = 2'b00;
        core_data_d  = core_data_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok_s) begin
                    req_ready_d  = req_onehot(arb_grant_s);
                    owner_d      = arb_grant_s;
                    last_grant_d = arb_grant_s;
                    cmd_d        = cmd_e'(gnt_cmd_s);
                    data_d       = gnt_data_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ISSUE: begin
                if (!CoreBusy) begin
                    case (cmd_q)
                        CMD_PUSH_LO: begin
                            push_lo_d   = 1'b1;
                            core_data_d = data_q;
                        end
                        CMD_PUSH_HI: begin
                            push_hi_d   = 1'b1;
                            core_data_d = data_q;
                        end
                        CMD_EXEC: begin
                            exec_d = 1'b1;
                            cnt_d  = {CNT_W{1'b0}};
                        end
                        default: begin
                            rsp_valid_d = req_onehot(owner_q);
                            rsp_data_d  = {RESULT_W{1'b0}};
                            rsp_error_d = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_seen_s) begin
                    rsp_valid_d = req_onehot(owner_q);
                    rsp_data_d  = CoreResult;
                    rsp_error_d = 1'b0;
                end else if (timeout_s) begin
                    rsp_valid_d = req_onehot(owner_q);
                    rsp_data_d  = {RESULT_W{1'b0}};
                    rsp_error_d = 1'b1;
                end else begin
                    rsp_valid_d = 2'b00;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    assign ReqReady    = req_ready_q;
    assign CorePushLow = push_lo_q;
    assign CorePushHi  = push_hi_q;
    assign CoreExecute = exec_q;
    assign CoreData    = core_data_q;
    assign RspValid    = rsp_valid_q;
    assign RspData     = rsp_data_q;
    assign RspError    = rsp_error_q;
    assign Owner       = owner_q;

endmodule

// File: doc/calc_cmd_arbiter.md
# calc_cmd_arbiter

Sequencer and arbiter for the calculator core's command port. It shares the core between two requesters: the debounced button panel and the UART command decoder. Accepted commands become single-cycle push/execute strobes, gated by core busy. Execute results, or errors, are routed back to the requester that issued the command. It sits between the input conditioning (synchronizers, debouncers, UART RX) and the calculator core in the board top level.

## Interface
- `DATA_W`, 8: operand width pushed to core
- `RESULT_W`, 16: core result width (4 hex digits)
- `TIMEOUT`, 1023: max cycles to wait for `CoreDone` after execute; must be ≥ 1

- `Clk` in 1: single clock, all logic rising-edge
- `RstN` in 1: asynchronous, active-low reset
- `ReqValid` in 2: per-requester request; bit 0 = buttons, bit 1 = UART; held until acked
- `ReqCmd` in 4: 2 bits per requester, `[2i+1:2i]`; 00 push low, 01 push hi, 10 execute, 11 reserved
- `ReqData` in 2·DATA_W: per-requester operand, slice i
- `ReqReady` out 2: one-cycle accept pulse to the granted requester
- `CorePushLow`, `CorePushHi`, `CoreExecute` out 1 each: one-cycle strobes, mutually exclusive
- `CoreData` out DATA_W: operand; valid with a push strobe
- `CoreBusy` in 1: core cannot accept a strobe
- `CoreDone` in 1: execute finished; `CoreResult` valid
- `CoreResult` in RESULT_W: execute result
- `RspValid` out 2: one-cycle response pulse to the owner
- `RspData` out RESULT_W: result; 0 on error
- `RspError` out 1: qualifies `RspValid`; 1 = timeout or reserved command
- `Owner` out 1: requester that holds or last held the core (LED indication)

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- **IDLE:** if any `ReqValid`, grant and move to ISSUE.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the requester ≠ `LastGrant`.
  - On grant: capture cmd/data, set `Owner` and `LastGrant`, and pulse `ReqReady[g]`.
- **ISSUE:**
  - Stays in ISSUE while `CoreBusy` = 1; no strobe is emitted.
  - When `CoreBusy` = 0, behaviour depends on the captured command:
    - push → matching push strobe with `CoreData` = captured data, then IDLE.
    - execute → `CoreExecute`, then WAIT_DONE with the counter cleared.
    - reserved → no strobe; go to RESP with error.
- **WAIT_DONE:**
  - The counter increments every cycle.
  - `CoreDone` = 1 → capture `CoreResult`, error = 0, go to RESP.
  - Counter reaches TIMEOUT without `CoreDone` → error = 1, data = 0, go to RESP.
  - `CoreDone` in the same cycle as timeout: Done wins.
- **RESP:** pulse `RspValid[Owner]` with `RspData`/`RspError`, then IDLE.
- Push commands produce no response.
- `CoreDone` outside WAIT_DONE is ignored.
- A requester dropping `ReqValid` after its grant has no effect; the captured command completes.
- Reset (any time, including mid-execute):
  - State → IDLE; `LastGrant` = 1, so requester 0 wins the first tie.
  - `Owner`, `CoreData`, `RspData`, and all strobes/pulses → 0; the counter is cleared.
  - An in-flight command is dropped; the core is not notified.

## Timing
- All outputs are registered; none are combinational from inputs.
- Push flow: `ReqValid` sampled at edge 0 → `ReqReady` high in cycle 1 → strobe high in cycle 2 (if `CoreBusy` was 0 at edge 1) → IDLE resamples at edge 3.
- Peak push throughput: one push per 3 cycles.
- Execute flow: `CoreExecute` in cycle 2. `CoreDone` first sampled at edge 3. With `CoreDone` sampled at edge n, `RspValid` is high in cycle n+1.
- Timeout: if no Done is seen, the error `RspValid` occurs TIMEOUT+1 cycles after the `CoreExecute` cycle.
- Each `CoreBusy` cycle in ISSUE delays the strobe by one cycle; stalls are unbounded.

## Structure
- Package `calc_cmd_pkg` holds:
  - command encodings (`CMD_PUSH_LO`, `CMD_PUSH_HI`, `CMD_EXEC`, `CMD_RSVD`);
  - the state enum;
  - the requester index constants (`REQ_BTN` = 0, `REQ_UART` = 1).
- Sub-module `rr_arbiter2`: a two-way round-robin grant from `ReqValid` and `LastGrant`. It is purely combinational; `LastGrant` is stored in the parent.
- Counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- Reset, then both requesters valid with push low: 0x12 (btn) and 0x34 (uart). Required: btn granted first, `CorePushLow`/0x12 in cycle 2, uart granted next with 0x34, then `Owner` = 1.
- Execute from UART, core asserts `CoreDone` 5 cycles after the strobe with `CoreResult` = 0xBEEF. Required: `RspValid` = 2'b10, `RspData` = 0xBEEF, `RspError` = 0, exactly one cycle.
- Execute with `TIMEOUT` = 8 and no Done. Required: `RspError` = 1, `RspData` = 0, 9 cycles after `CoreExecute`; a late `CoreDone` is ignored.
- `CoreBusy` held high for 4 cycles with a pending push hi. Required: `ReqReady` on time, strobe delayed exactly 4 cycles, data intact.
- Reserved command 11 from btn. Required: no core strobe; `RspValid[0]` with `RspError` = 1.
- `RstN` asserted while in WAIT_DONE. Required: all outputs 0 immediately. After release, a tie is won by requester 0.
